// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
// Purpose : shared types and constants for the two-requester RAM arbiter.
// Contents: arb_state_t FSM encoding, requester count, lock timeout length,
//           timer width/load value, and an owner-to-mask helper.
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

  localparam int NUM_REQ      = 2;
  localparam int LOCK_TIMEOUT = 16;
  localparam int TO_W         = 4;

  // Down-counter load value: expiry is the cycle the count sits at zero
  // while the owner is still idle, giving LOCK_TIMEOUT idle cycles in total.
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] owner_mask(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Purpose : combinational 2-way round-robin grant.
// Ports   : i_valid     - per-requester valid
//           i_rr_last   - index of the last granted requester
//           i_lock_mask - requesters currently allowed to win (all when idle,
//                         only the owner when locked)
//           o_grant     - one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_rr_last,
  input  logic [NUM_REQ-1:0] i_lock_mask,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [NUM_REQ-1:0] w_elig;

  always_comb begin
    w_elig = i_valid & i_lock_mask;
    if (w_elig == 2'b11)
      o_grant = i_rr_last ? 2'b01 : 2'b10;  // tie goes to the one not served last
    else
      o_grant = w_elig;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Purpose : arbitrates two requesters onto one single-port RAM with an
//           asynchronous read path. Supports a lock hint that keeps the grant
//           with one requester, released by an unlocked transfer or by a
//           16-cycle owner-idle timeout. Reads return one cycle later on a
//           shared registered data bus with per-requester strobes.
// Ports   : clk, rst_n (sync, active-low)
//           req_valid/lock/we [2], req_addr [2*ADDR_W], req_wdata [2*DATA_W]
//           req_ready [2], rsp_valid [2], rsp_rdata [DATA_W]
//           ram_addr, ram_data_in, ram_we  -> RAM
//           ram_data_out                   <- RAM (asynchronous)
//
// state  | meaning
// IDLE   | no owner; round-robin between valid requesters
// LOCKED | r_owner holds the grant; other requester is blocked
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_data_in,
  output logic                  ram_we,
  input  logic [DATA_W-1:0]     ram_data_out
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic               r_owner;
  logic               r_rr_last;
  logic [TO_W-1:0]    r_timer;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;

  logic [NUM_REQ-1:0] w_lock_mask;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic               w_gidx;
  logic               w_we_sel;
  logic               w_lock_sel;
  logic               w_owner_idle;
  logic               w_timeout;
  logic               w_rd_accept;

  rr_arbiter2 u_rr_arbiter2 (
    .i_valid     (req_valid),
    .i_rr_last   (r_rr_last),
    .i_lock_mask (w_lock_mask),
    .o_grant     (w_grant)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_accept && w_lock_sel) w_state_nxt = LOCKED;
      LOCKED: if ((w_accept && !w_lock_sel) || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs (grant qualification and RAM mux) ----
  always_comb begin
    w_lock_mask  = (r_state == LOCKED) ? owner_mask(r_owner) : {NUM_REQ{1'b1}};
    // ready is forced low while reset is held, independent of arbiter state
    w_ready      = w_grant & {NUM_REQ{rst_n}};
    w_accept     = |w_ready;
    w_gidx       = w_ready[1];
    w_we_sel     = req_we[w_gidx];
    w_lock_sel   = req_lock[w_gidx];
    w_rd_accept  = w_accept && !w_we_sel;
    w_owner_idle = !req_valid[r_owner];
    w_timeout    = (r_state == LOCKED) && w_owner_idle && (r_timer == '0);

    ram_we       = w_accept && w_we_sel;
    ram_addr     = '0;
    ram_data_in  = '0;
    if (w_accept) begin
      ram_addr    = w_gidx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      ram_data_in = w_gidx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end
  end

  // ---- owner / round-robin history ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
    end else if (w_accept) begin
      r_rr_last <= w_gidx;
      if (r_state == IDLE && w_lock_sel) r_owner <= w_gidx;
    end
  end

  // ---- lock timeout down-counter ----
  // Held at the load value while idle so entry to LOCKED starts a full count.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_timer <= '0;
    else if (r_state == IDLE || w_accept)
      r_timer <= TO_LOAD;
    else if (w_owner_idle && r_timer != '0)
      r_timer <= r_timer - 1'b1;
  end

  // ---- read response ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd_accept ? w_ready : '0;
      if (w_rd_accept) r_rsp_rdata <= ram_data_out;
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule
